// File: rtl/cp0_pkg.sv
// Shared constants for the MIPS32 CP0 register file: register numbers,
// exception codes, Status/Cause field positions and the default write masks.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int STATUS_IE      = 0;
  localparam int STATUS_EXL     = 1;
  localparam int STATUS_IM_LO   = 8;
  localparam int CAUSE_EXC_LO   = 2;
  localparam int CAUSE_IP_LO    = 8;
  localparam int CAUSE_IP_HW_LO = 10;
  localparam int CAUSE_BD       = 31;

  localparam logic [31:0] STATUS_WMASK_DEFAULT = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK_DEFAULT  = 32'h0000_0300;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count free-runs, timer_int latches on Count==Compare
// and is cleared by any write to Compare.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_load,
  input  logic        compare_load,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  always_comb begin
    count_d     = count_q + 32'd1;
    compare_d   = compare_q;
    timer_int_d = timer_int_q | (count_q == compare_q);
    if (count_load) count_d = wdata;
    // Clearing beats a same-edge match so software can always acknowledge.
    if (compare_load) begin
      compare_d   = wdata;
      timer_int_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// Architectural CP0 registers: combinational EX read port, committed mtc0
// writes, exception/eret state updates and the interrupt request.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] STATUS_WMASK = STATUS_WMASK_DEFAULT,
  parameter logic [31:0] CAUSE_WMASK  = CAUSE_WMASK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [5:0]  hw_int,
  input  logic        excp_valid,
  input  logic [4:0]  excp_code,
  input  logic [31:0] excp_pc,
  input  logic        excp_bd,
  input  logic [31:0] excp_badvaddr,
  input  logic        eret,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        int_req,
  output logic        timer_int
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count, compare;
  logic        count_load, compare_load;
  logic        exl;

  assign count_load   = we && (waddr == CP0_COUNT);
  assign compare_load = we && (waddr == CP0_COMPARE);
  assign exl          = status_q[STATUS_EXL];

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_load   (count_load),
    .compare_load (compare_load),
    .wdata        (wdata),
    .count_o      (count),
    .compare_o    (compare),
    .timer_int_o  (timer_int)
  );

  // mtc0 is applied first so exception/eret field updates override it.
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (we) begin
      case (waddr)
        CP0_STATUS:   status_d   = masked_write(status_q, wdata, STATUS_WMASK);
        CP0_CAUSE:    cause_d    = masked_write(cause_q, wdata, CAUSE_WMASK);
        CP0_EPC:      epc_d      = wdata;
        CP0_BADVADDR: badvaddr_d = wdata;
        default: ;
      endcase
    end

    cause_d[CAUSE_IP_HW_LO +: 6] = {hw_int[5] | timer_int, hw_int[4:0]};

    if (excp_valid) begin
      if (!exl) begin
        epc_d             = excp_bd ? (excp_pc - 32'd4) : excp_pc;
        cause_d[CAUSE_BD] = excp_bd;
      end
      cause_d[CAUSE_EXC_LO +: 5] = excp_code;
      status_d[STATUS_EXL]       = 1'b1;
      if ((excp_code == EXC_ADEL) || (excp_code == EXC_ADES))
        badvaddr_d = excp_badvaddr;
    end else if (eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= '0;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // No write bypass here: the EX forwarding mux handles in-flight mtc0.
  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_BADVADDR: rdata = badvaddr_q;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status_q;
      CP0_CAUSE:    rdata = cause_q;
      CP0_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

  assign int_req = status_q[STATUS_IE] & ~exl &
                   (|(cause_q[CAUSE_IP_LO +: 8] & status_q[STATUS_IM_LO +: 8]));

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset, timer, masking, exceptions,
// same-cycle collisions and interrupt gating against hand-computed values.
module tb_cp0_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [5:0]  hw_int;
  logic        excp_valid;
  logic [4:0]  excp_code;
  logic [31:0] excp_pc;
  logic        excp_bd;
  logic [31:0] excp_badvaddr;
  logic        eret;
  logic [31:0] status_o, cause_o, epc_o;
  logic        int_req, timer_int;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .raddr         (raddr),
    .rdata         (rdata),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .hw_int        (hw_int),
    .excp_valid    (excp_valid),
    .excp_code     (excp_code),
    .excp_pc       (excp_pc),
    .excp_bd       (excp_bd),
    .excp_badvaddr (excp_badvaddr),
    .eret          (eret),
    .status_o      (status_o),
    .cause_o       (cause_o),
    .epc_o         (epc_o),
    .int_req       (int_req),
    .timer_int     (timer_int)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change at negedge, outputs sampled 1 ns after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic excp(input logic [4:0] code, input logic [31:0] pc,
                      input logic bd, input logic [31:0] bva);
    @(negedge clk);
    excp_valid = 1'b1; excp_code = code; excp_pc = pc;
    excp_bd = bd; excp_badvaddr = bva;
    tick();
    excp_valid = 1'b0;
  endtask

  task automatic do_eret();
    @(negedge clk);
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; raddr = '0; we = 1'b0; waddr = '0; wdata = '0; hw_int = '0;
    excp_valid = 1'b0; excp_code = '0; excp_pc = '0; excp_bd = 1'b0;
    excp_badvaddr = '0; eret = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst_status", status_o, 32'h0);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_int_req", 32'(int_req), 32'h0);
    chk("rst_timer_int", 32'(timer_int), 32'h0);
    rd_chk("rst_rd_count", 5'd9, 32'h0);

    // Count==Compare==0 after reset sets timer_int on the first edge
    @(negedge clk); rst = 1'b0;
    tick();
    chk("timer_after_rst", 32'(timer_int), 32'h1);

    // async reset mid-count
    mtc0(5'd9, 32'h0000_1234);
    rd_chk("count_load", 5'd9, 32'h0000_1234);
    tick();
    rd_chk("count_inc", 5'd9, 32'h0000_1235);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_count", rdata, 32'h0);
    chk("async_rst_timer", 32'(timer_int), 32'h0);
    @(negedge clk); rst = 1'b0;

    // timer: Compare write clears the post-reset match
    mtc0(5'd11, 32'h0000_0010);
    chk("cmp_clear0", 32'(timer_int), 32'h0);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'h0000_000C);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("timer_low_e%0d", i), 32'(timer_int), 32'h0);
    end
    tick();
    chk("timer_rise_e5", 32'(timer_int), 32'h1);
    chk("int_req_e5", 32'(int_req), 32'h0);
    rd_chk("count_e5", 5'd9, 32'h0000_0011);
    tick();
    chk("int_req_e6", 32'(int_req), 32'h1);
    chk("cause_ip7", cause_o, 32'h0000_8000);
    mtc0(5'd11, 32'h0000_0010);
    chk("cmp_clear1", 32'(timer_int), 32'h0);
    tick();
    chk("int_req_drop", 32'(int_req), 32'h0);

    // match and Compare write on the same edge: clear wins
    mtc0(5'd9, 32'h0000_000F);
    tick();
    mtc0(5'd11, 32'h0000_0050);
    chk("clear_wins", 32'(timer_int), 32'h0);
    rd_chk("compare_rd", 5'd11, 32'h0000_0050);

    // Count wrap
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd_chk("count_max", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd_chk("count_wrap", 5'd9, 32'h0);

    // write masking
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd_chk("status_mask", 5'd12, 32'h0000_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd_chk("cause_mask", 5'd13, 32'h0000_0300);
    mtc0(5'd12, 32'h0);
    mtc0(5'd13, 32'h0);
    chk("status_clr", status_o, 32'h0);
    chk("cause_clr", cause_o, 32'h0);

    // unimplemented addresses
    mtc0(5'd0, 32'h0000_ABCD);
    rd_chk("rd_addr0", 5'd0, 32'h0);
    rd_chk("rd_addr10", 5'd10, 32'h0);
    rd_chk("rd_addr15", 5'd15, 32'h0);

    // exceptions
    excp(5'd4, 32'h8000_0104, 1'b1, 32'h0000_0001);
    chk("exc1_epc", epc_o, 32'h8000_0100);
    chk("exc1_cause", cause_o, 32'h8000_0010);
    chk("exc1_status", status_o, 32'h0000_0002);
    rd_chk("exc1_badvaddr", 5'd8, 32'h0000_0001);
    rd_chk("exc1_epc_rd", 5'd14, 32'h8000_0100);
    excp(5'd8, 32'h8000_0200, 1'b0, 32'h0000_0055);
    chk("exc2_epc", epc_o, 32'h8000_0100);
    chk("exc2_cause", cause_o, 32'h8000_0020);
    rd_chk("exc2_badvaddr", 5'd8, 32'h0000_0001);
    do_eret();
    chk("eret1_status", status_o, 32'h0);

    // collision: mtc0 Status with exception, then eret
    @(negedge clk);
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0001;
    excp_valid = 1'b1; excp_code = 5'd12; excp_pc = 32'h8000_0300; excp_bd = 1'b0;
    tick();
    we = 1'b0; excp_valid = 1'b0;
    chk("coll_status", status_o, 32'h0000_0003);
    chk("coll_epc", epc_o, 32'h8000_0300);
    do_eret();
    chk("coll_eret", status_o, 32'h0000_0001);

    // collision: mtc0 setting EXL with eret, eret wins on EXL only
    @(negedge clk);
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0403; eret = 1'b1;
    tick();
    we = 1'b0; eret = 1'b0;
    chk("eret_coll", status_o, 32'h0000_0401);

    // interrupt gating by EXL
    @(negedge clk); hw_int = 6'b00_0100;
    mtc0(5'd12, 32'h0000_1003);
    chk("gate_cause", cause_o, 32'h0000_1030);
    chk("gate_exl", 32'(int_req), 32'h0);
    do_eret();
    chk("gate_open", 32'(int_req), 32'h1);
    @(negedge clk); hw_int = 6'b0;
    tick();
    chk("gate_hw_off", 32'(int_req), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
